write_burst_master: RTL and testbench
=====================================

WRITE_BURST_MASTER -- requirements
Module: write_burst_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 48: byte address width.
REQ-002 Parameter DATA_WIDTH, default 512: beat width in bits; DATA_WIDTH/8 is the byte stride per beat.
REQ-003 Parameter BURST_WIDTH, default 3: burstcount width; MAX_BURST = 2^(BURST_WIDTH-1) beats.
REQ-004 Parameter LENGTH_WIDTH, default 16: command length width, in beats.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port cmd_address, input, ADDRESS_WIDTH: start byte address, beat-aligned.
REQ-008 Port cmd_length, input, LENGTH_WIDTH: total beats to write.
REQ-009 Port cmd_valid / cmd_ready, input / output, 1 each: command handshake.
REQ-010 Port st_data, input, DATA_WIDTH: write data stream.
REQ-011 Port st_valid / st_ready, input / output, 1 each: data stream handshake.
REQ-012 Ports m_address (ADDRESS_WIDTH), m_writedata (DATA_WIDTH), m_write (1), m_byteenable (DATA_WIDTH/8), m_burst (BURST_WIDTH), outputs: Avalon-MM burst write master, feeding write_response_bridge.
REQ-013 Ports m_waitrequest (1), m_response (2), m_write_response_valid (1), inputs: Avalon-MM slave feedback.
REQ-014 Port busy, output, 1: high whenever state is not IDLE.
REQ-015 Port done, output, 1: one-cycle pulse on command completion.
REQ-016 Port error, output, 1: sticky flag, set if any response is non-OKAY.

Function
REQ-017 The FSM SHALL have three states: IDLE, WRITE and DRAIN.
REQ-018 In IDLE, cmd_ready SHALL be 1; on cmd_valid&cmd_ready the block SHALL latch address/length, clear error, clear counters and enter WRITE, or enter DRAIN if cmd_length==0.
REQ-019 Burst size SHALL be min(MAX_BURST, remaining beats), computed at each burst start; m_burst SHALL hold that value for every beat of the burst.
REQ-020 m_address SHALL hold the burst start address for all beats of a burst, then advance by burst_size*DATA_WIDTH/8 (modulo 2^ADDRESS_WIDTH).
REQ-021 In WRITE: m_write = st_valid; st_ready = ~m_waitrequest; m_writedata = st_data (combinational); m_byteenable all ones.
REQ-022 A beat SHALL be accepted when m_write & ~m_waitrequest; the beat counter and remaining count SHALL update only on an accepted beat.
REQ-023 On the last beat of the last burst being accepted, the FSM SHALL move to DRAIN; outside WRITE, m_write=0 and st_ready=0.
REQ-024 The outstanding-burst counter SHALL increment on each burst's first accepted beat and decrement on m_write_response_valid; simultaneous events SHALL leave it unchanged. Width SHALL be LENGTH_WIDTH+1.
REQ-025 In DRAIN, the block SHALL move to IDLE when outstanding==0, with done=1 for exactly that transition cycle.
REQ-026 error SHALL set when m_write_response_valid & m_response!=2'b00, and SHALL hold until the next command is accepted.
REQ-027 Responses arriving while in IDLE SHALL be ignored; the counter SHALL NOT underflow below 0.
REQ-028 Write latency: st_data SHALL reach m_writedata in the same cycle (zero pipeline).

Reset
REQ-029 Asserting reset SHALL, immediately and at any time, force: state=IDLE, m_write=0, st_ready=0, cmd_ready=1 after release, busy=0, done=0, error=0, counters=0, m_burst=0, m_address=0.
REQ-030 Reset mid-burst SHALL abandon the command with no completion pulse.

Verification
REQ-031 cmd(addr=0x1000, len=4), st_valid=1, no waitrequest -> one burst: m_burst=4, m_address=0x1000 for 4 beats; 1 response -> done one cycle later, error=0.
REQ-032 len=10, MAX_BURST=4 -> bursts 4,4,2 at addresses 0x1000, 0x1100, 0x1200; done only after the 3rd response.
REQ-033 Hold m_waitrequest=1 for 3 cycles mid-burst -> m_writedata/address/burst stable, st_ready=0, beat count unchanged.
REQ-034 len=0 -> no m_write; busy for 1 cycle; done pulses.
REQ-035 Second response m_response=2'b10 on a len=8 command -> error=1 after done; next command clears error.
REQ-036 Assert reset during beat 2 of 4 -> m_write=0 asynchronously, busy=0, no done; a new command then completes normally.

Source files
------------

// File: rtl/write_burst_master_if.sv
// write_burst_master_if
// Groups the command, write-data stream and Avalon-MM burst write signals
// used by write_burst_master.
//   cmd_*  : command (start byte address, length in beats)
//   st_*   : write data stream
//   m_*    : Avalon-MM burst write master plus slave feedback
// Modports: master = the write_burst_master side, slave = the environment.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high. valid may not depend on ready; ready may depend on
// valid. On the Avalon side a beat is taken when m_write & ~m_waitrequest,
// and m_write_response_valid retires one whole burst.
interface write_burst_master_if #(
    parameter int ADDRESS_WIDTH = 48,
    parameter int DATA_WIDTH    = 512,
    parameter int BURST_WIDTH   = 3,
    parameter int LENGTH_WIDTH  = 16
);
    logic [ADDRESS_WIDTH-1:0]  cmd_address;
    logic [LENGTH_WIDTH-1:0]   cmd_length;
    logic                      cmd_valid;
    logic                      cmd_ready;

    logic [DATA_WIDTH-1:0]     st_data;
    logic                      st_valid;
    logic                      st_ready;

    logic [ADDRESS_WIDTH-1:0]  m_address;
    logic [DATA_WIDTH-1:0]     m_writedata;
    logic                      m_write;
    logic [DATA_WIDTH/8-1:0]   m_byteenable;
    logic [BURST_WIDTH-1:0]    m_burst;
    logic                      m_waitrequest;
    logic [1:0]                m_response;
    logic                      m_write_response_valid;

    modport master (
        input  cmd_address, cmd_length, cmd_valid,
        output cmd_ready,
        input  st_data, st_valid,
        output st_ready,
        output m_address, m_writedata, m_write, m_byteenable, m_burst,
        input  m_waitrequest, m_response, m_write_response_valid
    );

    modport slave (
        output cmd_address, cmd_length, cmd_valid,
        input  cmd_ready,
        output st_data, st_valid,
        input  st_ready,
        input  m_address, m_writedata, m_write, m_byteenable, m_burst,
        output m_waitrequest, m_response, m_write_response_valid
    );
endinterface

// File: rtl/write_burst_master.sv
// write_burst_master
// Turns a (start address, length) command plus a write-data stream into a
// sequence of Avalon-MM write bursts of up to MAX_BURST beats, then waits
// for one write response per burst before signalling completion.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   bus         : write_burst_master_if.master (command, stream, Avalon-MM)
//   busy        : high whenever the FSM is not IDLE
//   done        : one-cycle pulse as DRAIN returns to IDLE
//   error       : sticky, set by any non-OKAY response, cleared by next command
//   o_dbg_state : current FSM state (0 IDLE, 1 WRITE, 2 DRAIN)
module write_burst_master #(
    parameter int ADDRESS_WIDTH = 48,
    parameter int DATA_WIDTH    = 512,
    parameter int BURST_WIDTH   = 3,
    parameter int LENGTH_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    write_burst_master_if.master      bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                o_dbg_state
);
    localparam int MAX_BURST = 1 << (BURST_WIDTH - 1);
    localparam logic [LENGTH_WIDTH-1:0]  MAX_BURST_LEN = LENGTH_WIDTH'(MAX_BURST);
    localparam logic [ADDRESS_WIDTH-1:0] BEAT_BYTES    = ADDRESS_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    logic [ADDRESS_WIDTH-1:0]  r_address;
    logic [BURST_WIDTH-1:0]    r_burst;
    logic [BURST_WIDTH-1:0]    r_beat_cnt;
    logic [LENGTH_WIDTH-1:0]   r_remaining;
    logic [LENGTH_WIDTH:0]     r_outstanding;
    logic                      r_error;

    logic w_in_write;
    logic w_beat_accept;
    logic w_first_beat;
    logic w_last_in_burst;
    logic w_rsp;

    function automatic logic [BURST_WIDTH-1:0] burst_size(input logic [LENGTH_WIDTH-1:0] beats);
        burst_size = (beats > MAX_BURST_LEN) ? BURST_WIDTH'(MAX_BURST) : BURST_WIDTH'(beats);
    endfunction

    assign w_in_write      = (r_state == WRITE);
    assign w_beat_accept   = w_in_write & bus.st_valid & ~bus.m_waitrequest;
    assign w_first_beat    = w_beat_accept & (r_beat_cnt == '0);
    assign w_last_in_burst = w_beat_accept & (r_beat_cnt == r_burst - BURST_WIDTH'(1));
    // Responses seen while IDLE belong to no command and are dropped.
    assign w_rsp           = bus.m_write_response_valid & (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_address     <= '0;
            r_burst       <= '0;
            r_beat_cnt    <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_error       <= 1'b0;
        end else begin
            // A burst's first beat and a response in the same cycle cancel.
            if (w_first_beat && !w_rsp) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_first_beat && w_rsp && r_outstanding != '0) begin
                r_outstanding <= r_outstanding - 1'b1;
            end

            if (w_rsp && bus.m_response != 2'b00) begin
                r_error <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_address     <= bus.cmd_address;
                        r_remaining   <= bus.cmd_length;
                        r_burst       <= burst_size(bus.cmd_length);
                        r_beat_cnt    <= '0;
                        r_outstanding <= '0;
                        r_error       <= 1'b0;
                        r_state       <= (bus.cmd_length == '0) ? DRAIN : WRITE;
                    end
                end
                WRITE: begin
                    if (w_beat_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last_in_burst) begin
                            // Next burst is sized from what is left after this beat.
                            r_beat_cnt <= '0;
                            r_address  <= r_address + ADDRESS_WIDTH'(r_burst) * BEAT_BYTES;
                            r_burst    <= burst_size(r_remaining - 1'b1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                        if (r_remaining == LENGTH_WIDTH'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == IDLE);
    assign bus.m_write      = w_in_write & bus.st_valid;
    assign bus.st_ready     = w_in_write & ~bus.m_waitrequest;
    assign bus.m_writedata  = bus.st_data;
    assign bus.m_byteenable = '1;
    assign bus.m_address    = r_address;
    assign bus.m_burst      = r_burst;

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DRAIN) & (r_outstanding == '0);
    assign error       = r_error;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_write_burst_master.sv
// Directed bench for write_burst_master with default parameters
// (48-bit address, 512-bit data, MAX_BURST = 4, 16-bit length).
module tb_write_burst_master;
    logic       clk;
    logic       reset;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int bn       = 0;

    write_burst_master_if bus ();

    write_burst_master dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [511:0] make_data(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(n);
        make_data = {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle.
    task automatic send_cmd(input logic [47:0] addr, input logic [15:0] len);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_address = addr;
        bus.cmd_length = len;
        bus.st_valid = 1'b0;
        bus.m_waitrequest = 1'b0;
        bus.m_write_response_valid = 1'b0;
        #1;
        chk("cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));
    endtask

    // Offer one data beat with waitrequest low; it must be presented and taken.
    task automatic beat(input logic [47:0] ea, input logic [2:0] eb, input bit rv);
        logic [511:0] d;
        d = make_data(bn);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_data = d;
        bus.m_waitrequest = 1'b0;
        bus.m_write_response_valid = rv;
        bus.m_response = 2'b00;
        #1;
        chk("beat_m_write", 512'(bus.m_write), 512'(1'b1));
        chk("beat_st_ready", 512'(bus.st_ready), 512'(1'b1));
        chk("beat_address", 512'(bus.m_address), 512'(ea));
        chk("beat_burst", 512'(bus.m_burst), 512'(eb));
        chk("beat_data", bus.m_writedata, d);
        chk("beat_byteen", 512'(bus.m_byteenable), 512'({64{1'b1}}));
        bn++;
    endtask

    // Offer the pending beat while waitrequest is high; nothing may move.
    task automatic stall(input logic [47:0] ea, input logic [2:0] eb);
        logic [511:0] d;
        d = make_data(bn);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_data = d;
        bus.m_waitrequest = 1'b1;
        bus.m_write_response_valid = 1'b0;
        #1;
        chk("stall_m_write", 512'(bus.m_write), 512'(1'b1));
        chk("stall_st_ready", 512'(bus.st_ready), 512'(1'b0));
        chk("stall_address", 512'(bus.m_address), 512'(ea));
        chk("stall_burst", 512'(bus.m_burst), 512'(eb));
        chk("stall_data", bus.m_writedata, d);
    endtask

    // Non-beat cycle: st_valid stays high so gating of m_write is exercised.
    task automatic idle_cycle(input bit rv, input logic [1:0] code);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_data = make_data(999);
        bus.m_waitrequest = 1'b0;
        bus.m_write_response_valid = rv;
        bus.m_response = code;
        #1;
        chk("idle_m_write", 512'(bus.m_write), 512'(1'b0));
        chk("idle_st_ready", 512'(bus.st_ready), 512'(1'b0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_length = '0;
        bus.st_valid = 1'b1;
        bus.st_data = '0;
        bus.m_waitrequest = 1'b0;
        bus.m_response = 2'b00;
        bus.m_write_response_valid = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_write", 512'(bus.m_write), 512'(1'b0));
        chk("rst_st_ready", 512'(bus.st_ready), 512'(1'b0));
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_done", 512'(done), 512'(1'b0));
        chk("rst_error", 512'(error), 512'(1'b0));
        chk("rst_burst", 512'(bus.m_burst), 512'(0));
        chk("rst_address", 512'(bus.m_address), 512'(0));
        chk("rst_state", 512'(dbg_state), 512'(0));
        reset = 1'b0;
        idle_cycle(1'b0, 2'b00);
        chk("rel_cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));

        // Single 4-beat burst at 0x1000
        send_cmd(48'h1000, 16'd4);
        for (int i = 0; i < 4; i++) beat(48'h1000, 3'd4, 1'b0);
        idle_cycle(1'b1, 2'b00);
        chk("t1_drain_busy", 512'(busy), 512'(1'b1));
        chk("t1_drain_state", 512'(dbg_state), 512'(2));
        chk("t1_done_early", 512'(done), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t1_done", 512'(done), 512'(1'b1));
        chk("t1_error", 512'(error), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t1_done_clear", 512'(done), 512'(1'b0));
        chk("t1_busy_clear", 512'(busy), 512'(1'b0));

        // len=10 -> bursts 4,4,2; response coincides with burst-2 first beat
        send_cmd(48'h1000, 16'd10);
        for (int i = 0; i < 4; i++) beat(48'h1000, 3'd4, 1'b0);
        beat(48'h1100, 3'd4, 1'b1);
        for (int i = 0; i < 3; i++) beat(48'h1100, 3'd4, 1'b0);
        for (int i = 0; i < 2; i++) beat(48'h1200, 3'd2, 1'b0);
        idle_cycle(1'b1, 2'b00);
        chk("t2_done_r0", 512'(done), 512'(1'b0));
        idle_cycle(1'b1, 2'b00);
        chk("t2_done_r1", 512'(done), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t2_done", 512'(done), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);
        chk("t2_idle", 512'(busy), 512'(1'b0));

        // Stray error response while idle is ignored
        idle_cycle(1'b1, 2'b11);
        idle_cycle(1'b0, 2'b00);
        chk("idle_rsp_error", 512'(error), 512'(1'b0));
        chk("idle_rsp_done", 512'(done), 512'(1'b0));

        // len=0 -> straight to DRAIN, done with no writes
        send_cmd(48'h7000, 16'd0);
        idle_cycle(1'b0, 2'b00);
        chk("t4_busy", 512'(busy), 512'(1'b1));
        chk("t4_done", 512'(done), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);
        chk("t4_busy_clear", 512'(busy), 512'(1'b0));
        chk("t4_done_clear", 512'(done), 512'(1'b0));

        // Waitrequest held 3 cycles mid-burst
        send_cmd(48'h2000, 16'd4);
        beat(48'h2000, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) stall(48'h2000, 3'd4);
        for (int i = 0; i < 3; i++) beat(48'h2000, 3'd4, 1'b0);
        idle_cycle(1'b1, 2'b00);
        chk("t3_drain_state", 512'(dbg_state), 512'(2));
        idle_cycle(1'b0, 2'b00);
        chk("t3_done", 512'(done), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);
        chk("t3_idle", 512'(busy), 512'(1'b0));

        // len=8, second response is SLVERR
        send_cmd(48'h3000, 16'd8);
        for (int i = 0; i < 4; i++) beat(48'h3000, 3'd4, 1'b0);
        for (int i = 0; i < 4; i++) beat(48'h3100, 3'd4, 1'b0);
        idle_cycle(1'b1, 2'b00);
        chk("t5_error_pre", 512'(error), 512'(1'b0));
        idle_cycle(1'b1, 2'b10);
        chk("t5_done_early", 512'(done), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t5_done", 512'(done), 512'(1'b1));
        chk("t5_error_set", 512'(error), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);
        chk("t5_error_hold", 512'(error), 512'(1'b1));
        send_cmd(48'h4000, 16'd1);
        chk("t5_error_at_cmd", 512'(error), 512'(1'b1));
        beat(48'h4000, 3'd1, 1'b0);
        chk("t5_error_cleared", 512'(error), 512'(1'b0));
        idle_cycle(1'b1, 2'b00);
        chk("t5b_done_early", 512'(done), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t5b_done", 512'(done), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);

        // Reset during beat 2 of 4
        send_cmd(48'h5000, 16'd4);
        beat(48'h5000, 3'd4, 1'b0);
        beat(48'h5000, 3'd4, 1'b0);
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_data = make_data(bn);
        #1;
        chk("t6_beat2_write", 512'(bus.m_write), 512'(1'b1));
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_m_write", 512'(bus.m_write), 512'(1'b0));
        chk("t6_rst_busy", 512'(busy), 512'(1'b0));
        chk("t6_rst_done", 512'(done), 512'(1'b0));
        chk("t6_rst_st_ready", 512'(bus.st_ready), 512'(1'b0));
        chk("t6_rst_address", 512'(bus.m_address), 512'(0));
        chk("t6_rst_burst", 512'(bus.m_burst), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        idle_cycle(1'b0, 2'b00);
        chk("t6_no_done0", 512'(done), 512'(1'b0));
        chk("t6_cmd_ready", 512'(bus.cmd_ready), 512'(1'b1));
        idle_cycle(1'b0, 2'b00);
        chk("t6_no_done1", 512'(done), 512'(1'b0));
        send_cmd(48'h6000, 16'd2);
        beat(48'h6000, 3'd2, 1'b0);
        beat(48'h6000, 3'd2, 1'b0);
        idle_cycle(1'b1, 2'b00);
        chk("t6_done_early", 512'(done), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t6_done", 512'(done), 512'(1'b1));
        chk("t6_error", 512'(error), 512'(1'b0));
        idle_cycle(1'b0, 2'b00);
        chk("t6_idle", 512'(busy), 512'(1'b0));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
